// File: rtl/capture_seq_ctrl.sv
// capture_seq_ctrl: records a programmed run of generator samples into RAM,
// then serves stored words one at a time for APB readback.
module capture_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [31:0]       ctrl_word,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [31:0]       status_word,
    output logic              done
);
    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;
    logic start_q, rd_q, wrapped, start_ignored;
    logic start_edge, abort, cont, accept, last, rearm;
    logic [ADDR_W-1:0] wr_ptr, len, rd_idx;
    logic [15:0] total;
    logic unused_ctrl;

    assign start_edge  = ctrl_word[0] & ~start_q;
    assign abort       = ctrl_word[1];
    assign cont        = ctrl_word[2];
    assign len         = ctrl_word[8 +: ADDR_W];
    assign rd_idx      = ctrl_word[16 +: ADDR_W];
    assign unused_ctrl = ^ctrl_word;
    assign accept      = state == CAPTURE && !abort && sample_valid;
    assign last        = wr_ptr == len;
    assign rearm       = (state == IDLE || state == DONE) && !abort && start_edge;
    assign status_word = {total, 8'(wr_ptr), 4'd0, start_ignored, wrapped, state};

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, DONE: state_nxt = abort ? IDLE : start_edge ? CAPTURE : state;
            CAPTURE:    state_nxt = abort ? IDLE : (accept && last && !cont) ? DONE : CAPTURE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Write strobe, address and data are registered one cycle behind the accept.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            rd_q          <= 1'b0;
            wrapped       <= 1'b0;
            start_ignored <= 1'b0;
            wr_ptr        <= '0;
            total         <= '0;
            done          <= 1'b0;
            ram_we        <= 1'b0;
            ram_waddr     <= '0;
            ram_wdata     <= '0;
            ram_re        <= 1'b0;
            ram_raddr     <= '0;
            rd_data       <= '0;
        end else begin
            state     <= state_nxt;
            start_q   <= ctrl_word[0];
            done      <= state_nxt == DONE;
            ram_we    <= accept;
            ram_re    <= state_nxt != CAPTURE;
            ram_raddr <= rd_idx;
            rd_q      <= ram_re;
            if (rd_q)
                rd_data <= ram_rdata;
            if (rearm) begin
                wr_ptr        <= '0;
                total         <= '0;
                wrapped       <= 1'b0;
                start_ignored <= 1'b0;
            end
            if (state == CAPTURE && !abort && start_edge)
                start_ignored <= 1'b1;
            if (accept) begin
                ram_waddr <= wr_ptr;
                ram_wdata <= sample_data;
                total     <= total + 16'(total != 16'hFFFF);
                wr_ptr    <= last ? (cont ? '0 : wr_ptr) : wr_ptr + ADDR_W'(1);
                wrapped   <= wrapped | (last & cont);
            end
        end
    end
endmodule

// File: tb/tb_capture_seq_ctrl.sv
// tb_capture_seq_ctrl: directed scenarios plus randomized control traffic,
// checked cycle by cycle against a behavioural model with a shadow RAM.
module tb_capture_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic [31:0] ctrl_word = '0;
    logic [31:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        ram_we, ram_re, done;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [31:0] ram_wdata, ram_rdata, rd_data, status_word;

    always #5 clk = ~clk;

    capture_seq_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst_l(rst_l), .ctrl_word(ctrl_word),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .rd_data(rd_data), .status_word(status_word), .done(done)
    );

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    int          n_vec = 0, n_err = 0, we_cnt = 0;
    int          m_st, m_tot;
    bit          m_wrap, m_ign, m_done, m_prev, m_we, m_re, m_rdv, m_rdata_k, m_rd_k;
    logic [7:0]  m_ptr, m_waddr, m_raddr;
    logic [31:0] m_wdata, m_rdata, m_rd;
    logic [31:0] shadow [256];
    bit          known [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(bit s, bit a, bit c, logic [7:0] l, logic [7:0] i);
        return {8'd0, i, l, 5'd0, c, a, s};
    endfunction

    task automatic model_reset;
        m_st = 0; m_tot = 0; m_ptr = 0; m_wrap = 0; m_ign = 0; m_done = 0; m_prev = 0;
        m_we = 0; m_re = 0; m_raddr = 0; m_rdv = 0; m_rd = 0; m_rd_k = 1;
    endtask

    task automatic model_edge;
        bit st_edge, abort, cont, acc;
        logic [7:0] len;
        st_edge = ctrl_word[0] && !m_prev;
        abort = ctrl_word[1];
        cont = ctrl_word[2];
        len = ctrl_word[15:8];
        acc = 0;
        // RAM read returns contents from before this edge's write
        if (m_rdv) begin m_rd = m_rdata; m_rd_k = m_rdata_k; end
        m_rdv = m_re;
        if (m_re) begin m_rdata = shadow[m_raddr]; m_rdata_k = known[m_raddr]; end
        if (m_we) begin shadow[m_waddr] = m_wdata; known[m_waddr] = 1; end
        if (abort) begin
            m_st = 0; m_done = 0;
        end else if (m_st != 1) begin
            if (st_edge) begin
                m_st = 1; m_ptr = 0; m_tot = 0; m_wrap = 0; m_ign = 0; m_done = 0;
            end
        end else begin
            if (st_edge) m_ign = 1;
            if (sample_valid) begin
                acc = 1; m_waddr = m_ptr; m_wdata = sample_data;
                if (m_tot < 65535) m_tot++;
                if (m_ptr == len) begin
                    if (!cont) begin m_st = 2; m_done = 1; end
                    else begin m_ptr = 0; m_wrap = 1; end
                end else m_ptr++;
            end
        end
        m_we = acc;
        m_re = (m_st != 1);
        m_raddr = ctrl_word[23:16];
        m_prev = ctrl_word[0];
    endtask

    task automatic check_all;
        chk("status", status_word, {m_tot[15:0], m_ptr, 4'd0, m_ign, m_wrap, m_st[1:0]});
        chk("done", 32'(done), 32'(m_done));
        chk("ram_we", 32'(ram_we), 32'(m_we));
        if (ram_we) we_cnt++;
        if (m_we) begin
            chk("ram_waddr", 32'(ram_waddr), 32'(m_waddr));
            chk("ram_wdata", ram_wdata, m_wdata);
        end
        chk("ram_re", 32'(ram_re), 32'(m_re));
        if (m_re) chk("ram_raddr", 32'(ram_raddr), 32'(m_raddr));
        if (m_rd_k) chk("rd_data", rd_data, m_rd);
    endtask

    task automatic step(input logic [31:0] cw, input logic [31:0] d, input bit v);
        ctrl_word = cw; sample_data = d; sample_valid = v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_status"}, status_word, 0);
        chk({tag, "_flags"}, {28'd0, done, ram_we, ram_re, 1'b0}, 0);
        chk({tag, "_addr"}, {16'd0, ram_waddr, ram_raddr}, 0);
        chk({tag, "_wdata"}, ram_wdata, 0);
        chk({tag, "_rd"}, rd_data, 0);
    endtask

    task automatic do_reset(input int cycles);
        rst_l = 1'b0;
        #1 check_zero("rst_async");
        for (int i = 0; i < cycles; i++) begin
            ctrl_word = $urandom; sample_data = $urandom; sample_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_zero("rst_hold");
        end
        model_reset();
        rst_l = 1'b1;
    endtask

    bit st, ab, ct, v;
    logic [7:0] ln, ix;

    initial begin
        for (int i = 0; i < 256; i++) known[i] = 0;
        #2 do_reset(3);
        step(0, 0, 0);
        step(0, 0, 0);

        we_cnt = 0;
        step(mk(1, 0, 0, 3, 0), 0, 0);
        for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 3, 0), 32'h100 + i, 1);
        chk("oneshot_done", 32'(done), 1);
        chk("oneshot_state", 32'(status_word[1:0]), 2);
        chk("oneshot_ptr", 32'(status_word[15:8]), 3);
        chk("oneshot_total", 32'(status_word[31:16]), 4);
        step(mk(0, 0, 0, 3, 0), 0, 0);
        chk("oneshot_pulses", we_cnt, 4);

        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 3, 2), 0, 0);
        chk("readback", rd_data, 32'h102);

        step(mk(1, 0, 0, 1, 0), 0, 0);
        step(mk(1, 0, 0, 1, 0), 32'hA0, 1);
        step(mk(1, 0, 0, 1, 0), 32'hA1, 0);
        step(mk(1, 0, 0, 1, 0), 32'hA2, 0);
        chk("gap_busy", 32'(done), 0);
        step(mk(1, 0, 0, 1, 0), 32'hA3, 1);
        chk("gap_done", 32'(done), 1);
        step(mk(0, 0, 0, 1, 0), 0, 0);

        step(mk(1, 0, 1, 1, 0), 0, 0);
        for (int i = 0; i < 6; i++) step(mk(1, 0, 1, 1, 0), 32'hC0 + i, 1);
        step(mk(1, 1, 1, 1, 0), 0, 0);
        chk("cont_wrapped", 32'(status_word[2]), 1);
        chk("cont_total", 32'(status_word[31:16]), 6);
        chk("cont_idle", {done, status_word[1:0]}, 0);
        step(mk(0, 0, 0, 3, 0), 0, 0);

        step(mk(1, 0, 0, 3, 0), 0, 0);
        step(mk(1, 0, 0, 3, 0), 32'hD0, 1);
        step(mk(1, 0, 0, 3, 0), 32'hD1, 1);
        step(mk(0, 0, 0, 3, 0), 0, 0);
        step(mk(1, 0, 0, 3, 0), 0, 0);
        chk("busy_ignored", 32'(status_word[3]), 1);
        chk("busy_total", 32'(status_word[31:16]), 2);
        step(mk(1, 0, 0, 3, 0), 32'hD2, 1);
        step(mk(1, 0, 0, 3, 0), 32'hD3, 1);
        step(mk(0, 0, 0, 3, 0), 0, 0);
        step(mk(1, 1, 0, 3, 0), 0, 0);
        chk("abort_beats_start", 32'(status_word[1:0]), 0);
        step(mk(0, 0, 0, 3, 0), 0, 0);

        step(mk(1, 0, 0, 5, 0), 0, 0);
        step(mk(1, 0, 0, 5, 0), 32'hE0, 1);
        step(mk(1, 0, 0, 5, 0), 32'hE1, 1);
        do_reset(1);
        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 3), 0, 0);
        chk("reread", rd_data, shadow[3]);

        st = 0; ct = 0; ln = 2; ix = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) st = !st;
            ab = $urandom_range(0, 24) == 0;
            if ($urandom_range(0, 49) == 0) ct = !ct;
            if ($urandom_range(0, 39) == 0) ln = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ix = 8'($urandom_range(0, 7));
            v = !ab && $urandom_range(0, 1) == 1;
            step(mk(st, ab, ct, ln, ix), $urandom, v);
            if ($urandom_range(0, 399) == 0) do_reset(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/capture_seq_ctrl.md
# capture_seq_ctrl

Sequencing controller for the sample-capture path. It takes a control word from an APB register, records a programmed number of 32-bit generator samples into a single-port-write/single-port-read RAM, and then exposes stored words one at a time for APB readback. It sits between the code generator and the APB register block, and owns every RAM address and enable.

## Interface
- ADDR_W, 8, RAM address width; legal range 1..8 (length and index fields are 8 bits, upper bits ignored)
- DATA_W, 32, sample and RAM word width
- clk  in  1  single clock; all logic on rising edge
- rst_l  in  1  reset, asynchronous, active-low
- ctrl_word  in  32  APB control register: [0] start, [1] abort, [2] continuous, [15:8] len (capture len+1 words), [23:16] read index
- sample_data  in  DATA_W  generator sample
- sample_valid  in  1  sample_data valid this cycle
- ram_we  out  1  RAM write strobe
- ram_waddr  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- ram_re  out  1  RAM read enable
- ram_raddr  out  ADDR_W  RAM read address
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_re
- rd_data  out  DATA_W  last word read back, for APB
- status_word  out  32  [1:0] state, [2] wrapped, [3] start_ignored, [15:8] wr_ptr, [31:16] total accepted samples, saturating at 0xFFFF
- done  out  1  one-shot capture complete (high in DONE)

## Operation
- States: IDLE=0, CAPTURE=1, DONE=2. Encoding 3 is unreachable; if entered, go to IDLE.
- Start edge: ctrl_word[0]=1 while the registered previous value of bit 0 is 0. Only bit 0 is edge-detected.
- IDLE or DONE + start edge + abort=0 → CAPTURE. On that edge: wr_ptr=0, total=0, wrapped=0, start_ignored=0, done=0.
- CAPTURE, abort=1 → IDLE. done stays 0; wr_ptr, total and wrapped hold.
- DONE, abort=1 → IDLE and done clears.
- Abort has priority over a start edge in the same cycle, in every state.
- CAPTURE, start edge → ignored; start_ignored set (sticky until the next accepted start).
- CAPTURE, sample_valid=1 → sample accepted. Write it at wr_ptr, increment total (saturating), then:
  - if wr_ptr==len[ADDR_W-1:0] and continuous=0: go to DONE, done=1, wr_ptr=len.
  - if wr_ptr==len and continuous=1: wr_ptr=0, wrapped=1, stay in CAPTURE.
  - otherwise wr_ptr+1.
- sample_valid=0 → no write, no count. Gaps are allowed anywhere.
- len and continuous are sampled live each cycle. Changing them mid-capture takes effect at the next comparison.
- Readback in IDLE and DONE only:
  - ram_re=1 every cycle, ram_raddr = registered ctrl_word[ADDR_W+15:16].
  - rd_data captures ram_rdata the cycle after ram_re.
  - In CAPTURE: ram_re=0 and rd_data holds.

## Timing
- Reset values: state IDLE; ram_we=0, ram_waddr=0, ram_wdata=0, ram_re=0, ram_raddr=0, rd_data=0, status_word=0, done=0. The start-edge register resets to 0, so start held high through reset counts as an edge once rst_l deasserts.
- Start: edge seen in cycle N → state=CAPTURE after edge N. The first sample can be accepted at edge N+1.
- Write path is registered: a sample accepted at edge k drives ram_we=1, ram_waddr=its wr_ptr and ram_wdata=its data during cycle k+1. ram_we is 0 in all other cycles.
- On the last one-shot sample the DONE transition and done=1 appear at edge k; the RAM write completes during cycle k+1.
- Readback latency: index changes before edge R → ram_raddr updates at R → ram_rdata valid at R+1 → rd_data valid after edge R+2.
- Reset asserted mid-capture: immediate return to reset values. RAM contents are untouched.
- status_word is registered and reflects state/counters after the same edge.

## Test plan
- Reset: rst_l=0 with random inputs → all outputs 0. Release with ctrl_word=0 → state IDLE, no ram_we.
- One-shot, len=3, continuous=0:
  - Stimulus: start edge, then sample_valid=1 with data 0x100..0x103.
  - Required: writes addr0..3 = 0x100..0x103.
  - After the fourth accept: done=1, status_word[1:0]=2, wr_ptr=3, total=4, exactly four ram_we pulses.
- Valid gaps, len=1:
  - Stimulus: valid pattern 1,0,0,1.
  - Required: two writes, to addr0 and addr1. DONE only after the second valid.
- Continuous + abort, len=1:
  - Stimulus: six valid samples, then abort=1.
  - Required: addresses 0,1,0,1,0,1; wrapped=1; total=6; state IDLE after abort; done=0.
- Start while busy, and abort vs start:
  - A second start edge in CAPTURE → start_ignored=1, counters unaffected.
  - Abort and start edge together in DONE → IDLE, not CAPTURE.
- Readback and reset mid-capture:
  - After the one-shot run, set index=2 → rd_data=0x102 three cycles later.
  - Pulse rst_l low mid-capture → state IDLE, counters 0. A re-read then returns the previously written RAM data.
